// File: rtl/vme_wide_reg_bank_if.sv
// VME 16-bit word-access bus between the slave core and the wide register bank.
interface vme_wide_reg_bank_if;
    logic [19:1] vme_addr;
    logic [15:0] vme_rd_data;
    logic [15:0] vme_wr_data;
    logic        vme_rd_mem;
    logic        vme_wr_mem;
    logic        vme_rd_done;
    logic        vme_wr_done;

    modport master (
        output vme_addr, vme_wr_data, vme_rd_mem, vme_wr_mem,
        input  vme_rd_data, vme_rd_done, vme_wr_done
    );

    modport slave (
        input  vme_addr, vme_wr_data, vme_rd_mem, vme_wr_mem,
        output vme_rd_data, vme_rd_done, vme_wr_done
    );
endinterface

// File: rtl/vme_wide_reg_bank.sv
// Wide status/control register bank behind a 16-bit VME word bus; multi-word
// reads are made atomic by an MSW-triggered snapshot, writes commit on the LSW.
module vme_wide_reg_bank #(
    parameter int NREGS     = 2,
    parameter int REG_WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    vme_wide_reg_bank_if.slave         bus,
    input  logic [NREGS*REG_WIDTH-1:0] regs_i,
    output logic [NREGS*REG_WIDTH-1:0] regs_o,
    output logic [NREGS-1:0]           regs_wr_o
);
    localparam int WORDS = REG_WIDTH / 16;
    localparam int STG_W = (WORDS - 1) * 16;

    typedef struct packed {
        logic       stat;
        logic       ctrl;
        logic [2:0] ch;
        logic [2:0] wd;
    } dec_t;

    function automatic dec_t decode(input logic [18:0] addr);
        dec_t d;
        logic hs;
        logic hc;
        d = '0;
        for (int c = 0; c < NREGS; c++) begin
            for (int k = 0; k < WORDS; k++) begin
                hs     = (addr == 19'(c * WORDS + k));
                hc     = (addr == 19'(NREGS * WORDS + c * WORDS + k));
                d.stat = d.stat | hs;
                d.ctrl = d.ctrl | hc;
                d.ch   = (hs | hc) ? 3'(c) : d.ch;
                d.wd   = (hs | hc) ? 3'(k) : d.wd;
            end
        end
        return d;
    endfunction

    // Word 0 is the most-significant word of a register.
    function automatic logic [15:0] word_of(input logic [REG_WIDTH-1:0] v, input logic [2:0] k);
        return v[(WORDS - 1 - int'(k)) * 16 +: 16];
    endfunction

    dec_t                       rd_dec_s;
    dec_t                       wr_dec_s;
    logic [REG_WIDTH-1:0]       live_s;
    logic [REG_WIDTH-1:0]       ctrl_cur_s;
    logic [15:0]                rd_word_s;
    logic [15:0]                rd_data_nxt_s;
    logic                       snap_load_s;
    logic [STG_W-1:0]           stg_nxt_s;
    logic [NREGS*REG_WIDTH-1:0] regs_nxt_s;
    logic [NREGS-1:0]           wr_pulse_s;

    logic [15:0]                rd_data_r;
    logic                       rd_done_r;
    logic [REG_WIDTH-1:0]       snap_r;
    logic [2:0]                 snap_ch_r;
    logic                       snap_valid_r;
    logic                       wr_req_d0_r;
    logic [18:0]                wr_adr_d0_r;
    logic [15:0]                wr_dat_d0_r;
    logic [STG_W-1:0]           stg_r;
    logic [NREGS*REG_WIDTH-1:0] regs_r;
    logic [NREGS-1:0]           wr_pulse_r;

    // Read decode and data select; an MSW status read also requests a snapshot.
    always_comb begin
        rd_dec_s    = decode(bus.vme_addr);
        live_s      = regs_i[int'(rd_dec_s.ch) * REG_WIDTH +: REG_WIDTH];
        ctrl_cur_s  = regs_r[int'(rd_dec_s.ch) * REG_WIDTH +: REG_WIDTH];
        rd_word_s   = 16'h0000;
        snap_load_s = 1'b0;
        case ({rd_dec_s.stat, rd_dec_s.ctrl})
            2'b10: begin
                if (rd_dec_s.wd == 3'd0) begin
                    rd_word_s   = word_of(live_s, 3'd0);
                    snap_load_s = bus.vme_rd_mem;
                end else if (snap_valid_r && (snap_ch_r == rd_dec_s.ch)) begin
                    rd_word_s = word_of(snap_r, rd_dec_s.wd);
                end else begin
                    rd_word_s = word_of(live_s, rd_dec_s.wd);
                end
            end
            2'b01:   rd_word_s = word_of(ctrl_cur_s, rd_dec_s.wd);
            default: rd_word_s = 16'h0000;
        endcase
        if (bus.vme_rd_mem) begin
            rd_data_nxt_s = rd_word_s;
        end else begin
            rd_data_nxt_s = rd_data_r;
        end
    end

    // Write decode on the registered request: stage upper words, commit on the LSW.
    always_comb begin
        wr_dec_s   = decode(wr_adr_d0_r);
        stg_nxt_s  = stg_r;
        regs_nxt_s = regs_r;
        wr_pulse_s = '0;
        if (wr_req_d0_r && wr_dec_s.ctrl) begin
            if (wr_dec_s.wd == 3'(WORDS - 1)) begin
                regs_nxt_s[int'(wr_dec_s.ch) * REG_WIDTH +: REG_WIDTH] = {stg_r, wr_dat_d0_r};
                wr_pulse_s = NREGS'(1'b1) << wr_dec_s.ch;
            end else begin
                stg_nxt_s[(WORDS - 2 - int'(wr_dec_s.wd)) * 16 +: 16] = wr_dat_d0_r;
            end
        end else begin
            wr_pulse_s = '0;
        end
    end

    // Read-side registers: data, acknowledge and the shared snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r    <= 16'h0000;
            rd_done_r    <= 1'b0;
            snap_r       <= '0;
            snap_ch_r    <= 3'd0;
            snap_valid_r <= 1'b0;
        end else begin
            rd_data_r <= rd_data_nxt_s;
            rd_done_r <= bus.vme_rd_mem;
            if (snap_load_s) begin
                snap_r       <= live_s;
                snap_ch_r    <= rd_dec_s.ch;
                snap_valid_r <= 1'b1;
            end
        end
    end

    // Write-side registers: request pipeline, staging, control registers, pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_req_d0_r <= 1'b0;
            wr_adr_d0_r <= 19'd0;
            wr_dat_d0_r <= 16'h0000;
            stg_r       <= '0;
            regs_r      <= '0;
            wr_pulse_r  <= '0;
        end else begin
            wr_req_d0_r <= bus.vme_wr_mem;
            wr_adr_d0_r <= bus.vme_addr;
            wr_dat_d0_r <= bus.vme_wr_data;
            stg_r       <= stg_nxt_s;
            regs_r      <= regs_nxt_s;
            wr_pulse_r  <= wr_pulse_s;
        end
    end

    assign bus.vme_rd_data = rd_data_r;
    assign bus.vme_rd_done = rd_done_r;
    assign bus.vme_wr_done = wr_req_d0_r;
    assign regs_o          = regs_r;
    assign regs_wr_o       = wr_pulse_r;
endmodule
